fc_layer_engine: RTL



---
 rtl/fc_layer_engine.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/fc_layer_engine.sv
// fc_layer_engine
//   Fully-connected (dense) layer engine. Input elements arrive one per
//   handshake beat. Each element is held for GROUPS cycles while LANES
//   parallel MACs accumulate it against one weight row per group. A bias row
//   per group is then added, and the sum is scaled, saturated and optionally
//   rectified. All N_OUT results are presented in parallel under valid/ready.
//
//   Build option: define FC_RELU_EN to clamp negative results to zero (ReLU
//   output layer). When it is undefined, signed saturated logits pass through.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse; begins a frame when idle
//   clr                 synchronous abort back to idle (highest priority)
//   in_valid/in_ready   input element handshake; in_ready marks consumption
//   in_data   [DW]      signed input element
//   w_addr    [WAW]     weight row address = elem*GROUPS + grp
//   w_rdata   [LANES*WW] weight row, lane k at [k*WW +: WW], 1-cycle latency
//   b_addr    [BAW]     bias row address
//   b_rdata   [LANES*WW] bias row, 1-cycle latency
//   out_valid/out_ready result vector handshake
//   out_data  [N_OUT*DW] neuron n at [n*DW +: DW]
//   busy                engine not idle
module fc_layer_engine #(
  parameter int DW    = 18,
  parameter int WW    = 9,
  parameter int AW    = 36,
  parameter int N_IN  = 100,
  parameter int N_OUT = 64,
  parameter int LANES = 16,
  parameter int SHIFT = 8,
  localparam int GROUPS = N_OUT / LANES,
  localparam int WAW = (N_IN * GROUPS > 1) ? $clog2(N_IN * GROUPS) : 1,
  localparam int BAW = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DW-1:0]         in_data,
  output logic [WAW-1:0]        w_addr,
  input  logic [LANES*WW-1:0]   w_rdata,
  output logic [BAW-1:0]        b_addr,
  input  logic [LANES*WW-1:0]   b_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_OUT*DW-1:0]   out_data,
  output logic                  busy
);

  localparam int EW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PW = DW + WW;
  localparam logic [EW-1:0]  ELEM_LAST = EW'(N_IN - 1);
  localparam logic [BAW-1:0] GRP_LAST  = BAW'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

  state_t state, state_nxt;

  logic [EW-1:0]  elem;
  logic [BAW-1:0] grp;
  logic           issue;
  logic           b_done;

  logic                 vld_p1;
  logic [BAW-1:0]       grp_p1;
  logic signed [DW-1:0] x_p1;
  logic                 b_vld_p1;
  logic [BAW-1:0]       b_grp_p1;

  logic signed [AW-1:0] acc [GROUPS][LANES];
  logic signed [DW-1:0] res [GROUPS][LANES];

  // Full-precision signed product, sign-extended to the accumulator width.
  function automatic logic signed [AW-1:0] mac_term(input logic signed [DW-1:0] x,
                                                    input logic signed [WW-1:0] w);
    logic signed [PW-1:0] p;
    p = x * w;
    return {{(AW-PW){p[PW-1]}}, p};
  endfunction

  // Bias add with one guard bit, arithmetic shift, then clamp to DW bits.
  function automatic logic signed [DW-1:0] scale_sat(input logic signed [AW-1:0] a,
                                                     input logic signed [WW-1:0] b);
    logic signed [AW:0]   s;
    logic [AW-DW+1:0]     top;
    s = $signed({a[AW-1], a}) + $signed({{(AW+1-WW){b[WW-1]}}, b});
    s = s >>> SHIFT;
    top = s[AW:DW-1];
    if (&top || ~|top)
      return s[DW-1:0];
    else if (s[AW])
      return {1'b1, {(DW-1){1'b0}}};
    else
      return {1'b0, {(DW-1){1'b1}}};
  endfunction

  function automatic logic signed [DW-1:0] rectify(input logic signed [DW-1:0] r);
`ifdef FC_RELU_EN
    return r[DW-1] ? '0 : r;
`else
    return r;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (in_valid) begin
          issue = 1'b1;
          if (grp == GRP_LAST) begin
            in_ready = 1'b1;
            if (elem == ELEM_LAST) state_nxt = BIAS;
          end
        end
      end
      BIAS: begin
        // Leave once the final group's result is being written.
        if (b_vld_p1 && b_grp_p1 == GRP_LAST) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
      issue     = 1'b0;
      in_ready  = 1'b0;
    end
  end

  // Issue stage: address counters and MAC/bias pipeline control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem     <= '0;
      grp      <= '0;
      w_addr   <= '0;
      b_addr   <= '0;
      b_done   <= 1'b0;
      vld_p1   <= 1'b0;
      grp_p1   <= '0;
      b_vld_p1 <= 1'b0;
      b_grp_p1 <= '0;
    end else if (clr) begin
      vld_p1   <= 1'b0;
      b_vld_p1 <= 1'b0;
    end else begin
      vld_p1   <= issue;
      b_vld_p1 <= 1'b0;
      if (state == IDLE && start) begin
        elem   <= '0;
        grp    <= '0;
        w_addr <= '0;
        b_addr <= '0;
        b_done <= 1'b0;
      end
      if (issue) begin
        grp_p1 <= grp;
        if (grp == GRP_LAST) begin
          grp  <= '0;
          elem <= (elem == ELEM_LAST) ? '0 : elem + 1'b1;
        end else begin
          grp <= grp + 1'b1;
        end
        w_addr <= (grp == GRP_LAST && elem == ELEM_LAST) ? '0 : w_addr + 1'b1;
      end
      if (state == BIAS && !b_done) begin
        b_vld_p1 <= 1'b1;
        b_grp_p1 <= b_addr;
        if (b_addr == GRP_LAST)
          b_done <= 1'b1;
        else
          b_addr <= b_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue) x_p1 <= in_data;
  end

  // MAC stage: weight row arrives the cycle after its address was issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < GROUPS; g++)
        for (int k = 0; k < LANES; k++)
          acc[g][k] <= '0;
    end else if (!clr) begin
      if (state == IDLE && start) begin
        for (int g = 0; g < GROUPS; g++)
          for (int k = 0; k < LANES; k++)
            acc[g][k] <= '0;
      end else if (vld_p1) begin
        for (int k = 0; k < LANES; k++)
          acc[grp_p1][k] <= acc[grp_p1][k] + mac_term(x_p1, $signed(w_rdata[k*WW +: WW]));
      end
    end
  end

  // Bias stage: bias row arrives the cycle after b_addr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < GROUPS; g++)
        for (int k = 0; k < LANES; k++)
          res[g][k] <= '0;
    end else if (!clr && b_vld_p1) begin
      for (int k = 0; k < LANES; k++)
        res[b_grp_p1][k] <= rectify(scale_sat(acc[b_grp_p1][k], $signed(b_rdata[k*WW +: WW])));
    end
  end

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign out_data[(g*LANES+k)*DW +: DW] = res[g][k];
    end
  end

endmodule
